ifetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request handshake and holds the IF/ID pipeline register (IDIR/IDPC) consumed by the ID-stage controller. Obeys the controller's stall (WPCIR), redirect (BRANCH with target) and self-modifying-code refetch (SMC). A one-entry skid buffer absorbs instructions returned while ID is stalled, so memory handshakes are never abandoned.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch_skid.sv | 43 ++++
 rtl/ifetch_stage.sv | 129 ++++++++++++
 tb/tb_ifetch_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants, FSM state type and address helper for the instruction-fetch stage.
package ifetch_pkg;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BUF   = 2'd2
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/ifetch_skid.sv
// One-entry {instr, pc} skid buffer; load wins over clear in the same cycle.
module ifetch_skid import ifetch_pkg::*; (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        vld,
  output logic [31:0] instr,
  output logic [31:0] pc
);
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d, pc_q, pc_d;

  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) vld_d = 1'b0;
    if (load) begin
      vld_d   = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      vld_q   <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
    end else begin
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign vld   = vld_q;
  assign instr = instr_q;
  assign pc    = pc_q;
endmodule

// File: rtl/ifetch_stage.sv
// MIPS IF stage: PC, imem handshake, IF/ID register and skid buffer.
// IFETCH_DELAY_SLOT_EN: deliver the instruction after a branch instead of squashing it.
module ifetch_stage import ifetch_pkg::*; #(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        WPCIR,
  input  logic        BRANCH,
  input  logic [31:0] BPC,
  input  logic        SMC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IDIR,
  output logic [31:0] IDPC,
  output logic        IDVALID
);
`ifdef IFETCH_DELAY_SLOT_EN
  localparam logic DS_EN = 1'b1;
`else
  localparam logic DS_EN = 1'b0;
`endif

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d, idir_q, idir_d, idpc_q, idpc_d;
  logic        idvalid_q, idvalid_d, pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        skid_load, skid_clear, skid_vld;
  logic [31:0] skid_instr, skid_pc;
  logic        redirect, squash_ack, squash_skid;
  logic [31:0] tgt;

  assign redirect    = BRANCH && !WPCIR;
  assign tgt         = word_align(BPC);
  // Whatever belongs to the old stream is dropped unless it is the delay slot.
  assign squash_ack  = !DS_EN && (redirect || pend_q);
  assign squash_skid = !DS_EN && redirect;

  ifetch_skid u_skid (
    .CLK(CLK), .RSTN(RSTN), .load(skid_load), .clear(skid_clear),
    .in_instr(IMEM_RDATA), .in_pc(pc_q),
    .vld(skid_vld), .instr(skid_instr), .pc(skid_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    idir_d      = idir_q;
    idpc_d      = idpc_q;
    idvalid_d   = idvalid_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    if (SMC) begin
      pc_d       = idpc_q;
      skid_clear = 1'b1;
      idir_d     = NOP_INSTR;
      idvalid_d  = 1'b0;
      pend_d     = 1'b0;
      state_d    = FETCH;
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          // ADDR must stay put until ACK, so a redirect waits in PEND.
          if (redirect) begin
            pend_d      = 1'b1;
            pend_addr_d = tgt;
          end
          if (IMEM_ACK) begin
            pend_d = 1'b0;
            pc_d   = redirect ? tgt : (pend_q ? pend_addr_q : pc_q + 32'd4);
            if (!WPCIR) begin
              idir_d    = squash_ack ? NOP_INSTR : IMEM_RDATA;
              idpc_d    = squash_ack ? idpc_q : pc_q;
              idvalid_d = !squash_ack;
            end else if (!squash_ack) begin
              skid_load = 1'b1;
              state_d   = BUF;
            end
          end else if (!WPCIR) begin
            idir_d    = NOP_INSTR;
            idvalid_d = 1'b0;
          end
        end
        BUF: begin
          if (!WPCIR) begin
            skid_clear = 1'b1;
            state_d    = FETCH;
            idir_d     = (skid_vld && !squash_skid) ? skid_instr : NOP_INSTR;
            idpc_d     = (skid_vld && !squash_skid) ? skid_pc : idpc_q;
            idvalid_d  = skid_vld && !squash_skid;
            if (redirect) pc_d = tgt;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VEC;
      idir_q      <= NOP_INSTR;
      idpc_q      <= 32'h0;
      idvalid_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      idir_q      <= idir_d;
      idpc_q      <= idpc_d;
      idvalid_q   <= idvalid_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign IMEM_REQ  = (state_q == FETCH);
  assign IMEM_ADDR = pc_q;
  assign IDIR      = idir_q;
  assign IDPC      = idpc_q;
  assign IDVALID   = idvalid_q;
endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with an in-order instruction-stream model and handshake checks.
module tb_ifetch_stage;
  logic        CLK = 1'b0, RSTN = 1'b0, WPCIR = 1'b0, BRANCH = 1'b0, SMC = 1'b0;
  logic [31:0] BPC = 32'h0;
  logic        IMEM_REQ, IMEM_ACK, IDVALID;
  logic [31:0] IMEM_ADDR, IMEM_RDATA, IDIR, IDPC;

  int n_chk = 0, n_pass = 0;
  int nwait = 0, nwait_q = 0, wcnt = 0, n10 = 0;

`ifdef IFETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  ifetch_stage dut (
    .CLK(CLK), .RSTN(RSTN), .WPCIR(WPCIR), .BRANCH(BRANCH), .BPC(BPC), .SMC(SMC),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .IDIR(IDIR), .IDPC(IDPC), .IDVALID(IDVALID)
  );

  always #5 CLK = ~CLK;

  // Memory: data is the inverted address, ACK after nwait_q wait cycles.
  assign IMEM_ACK   = IMEM_REQ && (wcnt >= nwait_q);
  assign IMEM_RDATA = ~IMEM_ADDR;

  always @(posedge CLK) begin
    nwait_q <= nwait;
    wcnt    <= (IMEM_REQ && !IMEM_ACK) ? wcnt + 1 : 0;
    if (IMEM_REQ && IMEM_ACK && IMEM_ADDR == 32'h10) n10 <= n10 + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Stream model: valid deliveries must follow the program order implied by
  // sequential fetch, redirects, delay slots and SMC refetch.
  logic [31:0] exp_next = 32'h0, ds_tgt = 32'h0;
  logic        ds_pend = 1'b0;
  logic        p_req = 1'b0, p_ack = 1'b0, p_vld = 1'b0;
  logic [31:0] p_addr = 32'h0, p_idir = 32'h0, p_idpc = 32'h0;

  always @(posedge CLK) begin
    #1;
    if (!RSTN) begin
      chk("rst_req", 32'(IMEM_REQ), 0);
      chk("rst_addr", IMEM_ADDR, 32'h0);
      chk("rst_idvalid", 32'(IDVALID), 0);
      chk("rst_idir", IDIR, 32'h0);
      chk("rst_idpc", IDPC, 32'h0);
      exp_next = 32'h0;
      ds_pend  = 1'b0;
    end else if (SMC) begin
      chk("smc_bubble_vld", 32'(IDVALID), 0);
      chk("smc_bubble_ir", IDIR, 32'h0);
      exp_next = p_idpc;
      ds_pend  = 1'b0;
    end else if (WPCIR) begin
      chk("stall_hold_vld", 32'(IDVALID), 32'(p_vld));
      chk("stall_hold_ir", IDIR, p_idir);
      chk("stall_hold_pc", IDPC, p_idpc);
    end else begin
      if (BRANCH) begin
        if (DS) begin
          ds_pend = 1'b1;
          ds_tgt  = BPC & 32'hFFFF_FFFC;
        end else exp_next = BPC & 32'hFFFF_FFFC;
      end
      if (IDVALID) begin
        chk("stream_pc", IDPC, exp_next);
        chk("stream_ir", IDIR, ~IDPC);
        exp_next = IDPC + 32'd4;
        if (ds_pend) begin
          exp_next = ds_tgt;
          ds_pend  = 1'b0;
        end
      end else chk("bubble_ir", IDIR, 32'h0);
    end
    if (RSTN && !SMC && p_req && !p_ack) begin
      chk("req_hold", 32'(IMEM_REQ), 1);
      chk("addr_hold", IMEM_ADDR, p_addr);
    end
    if (IMEM_REQ) chk("addr_align", 32'(IMEM_ADDR[1:0]), 0);
    p_req  = IMEM_REQ;
    p_ack  = IMEM_ACK;
    p_addr = IMEM_ADDR;
    p_vld  = IDVALID;
    p_idir = IDIR;
    p_idpc = IDPC;
  end

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic wait_pc(input string nm, input logic [31:0] pc, input int bound);
    int k;
    k = 0;
    while (!(IDVALID && IDPC == pc) && k < bound) begin
      cyc();
      k++;
    end
    chk(nm, (IDVALID && IDPC == pc) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int k, gap;
    repeat (3) cyc();
    chk("lit_rst_req", 32'(IMEM_REQ), 0);
    chk("lit_rst_addr", IMEM_ADDR, 32'h0);
    RSTN = 1'b1;
    cyc();
    chk("lit_idle_req", 32'(IMEM_REQ), 1);
    chk("lit_idle_vld", 32'(IDVALID), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("lit_seq_pc", IDPC, 32'(4 * i));
      chk("lit_seq_vld", 32'(IDVALID), 1);
    end

    // Stall while 0x10 is acknowledged
    WPCIR = 1'b1;
    repeat (3) begin
      cyc();
      chk("lit_stall_pc", IDPC, 32'hC);
    end
    chk("lit_buf_req", 32'(IMEM_REQ), 0);
    WPCIR = 1'b0;
    cyc();
    chk("lit_unstall_pc", IDPC, 32'h10);
    chk("lit_unstall_vld", 32'(IDVALID), 1);
    chk("lit_unstall_addr", IMEM_ADDR, 32'h14);

    // Zero-wait redirect
    wait_pc("reach_20", 32'h20, 20);
    chk("lit_no_refetch_10", n10, 1);
    BRANCH = 1'b1; BPC = 32'h103;
    cyc();
    BRANCH = 1'b0;
    chk("lit_br_addr", IMEM_ADDR, 32'h100);
    chk("lit_slot_vld", 32'(IDVALID), 32'(DS));
`ifdef IFETCH_DELAY_SLOT_EN
    chk("lit_slot_pc", IDPC, 32'h24);
`endif
    cyc();
    chk("lit_tgt_pc", IDPC, 32'h100);
    chk("lit_tgt_vld", 32'(IDVALID), 1);

    // Two-wait memory
    nwait = 2;
    cyc();
    chk("lit_w_first", IDPC, 32'h104);
    for (int i = 0; i < 3; i++) begin
      gap = 0;
      do begin
        cyc();
        gap++;
      end while (!IDVALID && gap < 10);
      chk("lit_w_gap", gap, 3);
    end

    // Redirect during wait state on 0x40
    BRANCH = 1'b1; BPC = 32'h38;
    cyc();
    BRANCH = 1'b0;
    k = 0;
    while (!(IMEM_REQ && IMEM_ADDR == 32'h40) && k < 40) begin
      cyc();
      k++;
    end
    chk("reach_40", IMEM_ADDR, 32'h40);
    BRANCH = 1'b1; BPC = 32'h200;
    cyc();
    BRANCH = 1'b0;
    chk("lit_wb_hold0", IMEM_ADDR, 32'h40);
    cyc();
    chk("lit_wb_hold1", IMEM_ADDR, 32'h40);
    cyc();
    chk("lit_wb_tgt_addr", IMEM_ADDR, 32'h200);
    chk("lit_wb_slot_vld", 32'(IDVALID), 32'(DS));
    repeat (3) cyc();
    chk("lit_wb_tgt_pc", IDPC, 32'h200);
    chk("lit_wb_tgt_vld", 32'(IDVALID), 1);

    // SMC while stalled
    nwait = 0;
    BRANCH = 1'b1; BPC = 32'h28;
    cyc();
    BRANCH = 1'b0;
    wait_pc("reach_30", 32'h30, 30);
    WPCIR = 1'b1; SMC = 1'b1;
    cyc();
    SMC = 1'b0;
    chk("lit_smc_vld", 32'(IDVALID), 0);
    chk("lit_smc_ir", IDIR, 32'h0);
    chk("lit_smc_addr", IMEM_ADDR, 32'h30);
    chk("lit_smc_req", 32'(IMEM_REQ), 1);
    cyc();
    chk("lit_smc_stall_vld", 32'(IDVALID), 0);
    WPCIR = 1'b0;
    cyc();
    chk("lit_smc_pc", IDPC, 32'h30);
    chk("lit_smc_ir2", IDIR, ~32'h30);
    chk("lit_smc_vld2", 32'(IDVALID), 1);

    // PC wrap
    BRANCH = 1'b1; BPC = 32'hFFFF_FFF8;
    cyc();
    BRANCH = 1'b0;
    wait_pc("reach_fffc", 32'hFFFF_FFFC, 10);
    cyc();
    chk("lit_wrap_pc", IDPC, 32'h0);
    chk("lit_wrap_vld", 32'(IDVALID), 1);

    // Reset in the middle of a wait-stated handshake
    nwait = 3;
    repeat (3) cyc();
    chk("lit_pre_rst_req", 32'(IMEM_REQ), 1);
    RSTN = 1'b0;
    cyc();
    chk("lit_mid_rst_req", 32'(IMEM_REQ), 0);
    chk("lit_mid_rst_addr", IMEM_ADDR, 32'h0);
    chk("lit_mid_rst_vld", 32'(IDVALID), 0);
    nwait = 0;
    cyc();
    RSTN = 1'b1;
    wait_pc("post_rst_0", 32'h0, 5);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
